// File: rtl/hex_raster_pkg.sv
// Shared types and constants for the hex rasterizer back end.
package hex_raster_pkg;

  typedef logic signed [15:0] hex_coord_t;
  typedef logic [7:0]         hex_depth_t;
  typedef logic [7:0]         hex_mat_t;

  localparam int         HEX_BATCH     = 10;
  localparam hex_depth_t HEX_PAD_DEPTH = 8'hFF;
  localparam hex_coord_t HEX_PAD_COORD = 16'sh8000;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FLUSH   = 2'd2
  } batch_state_e;

endpackage

// File: rtl/hex_batch_stats.sv
// Saturating batch / pad-slot counters for hex_event_batcher (HEX_BATCH_STATS_EN builds only).
module hex_batch_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        transfer,
  input  logic [3:0]  pad_add,
  output logic [31:0] stat_batches,
  output logic [31:0] stat_pad_slots
);

  logic [32:0] pad_sum_s;

  // Widened sum so an overflow can be detected and clamped.
  always_comb begin
    pad_sum_s = {1'b0, stat_pad_slots} + {29'd0, pad_add};
  end

  // Counter registers: clear on frame start, saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_batches   <= 32'd0;
      stat_pad_slots <= 32'd0;
    end else if (clear) begin
      stat_batches   <= 32'd0;
      stat_pad_slots <= 32'd0;
    end else if (transfer) begin
      if (stat_batches != 32'hFFFF_FFFF) begin
        stat_batches <= stat_batches + 32'd1;
      end
      stat_pad_slots <= pad_sum_s[32] ? 32'hFFFF_FFFF : pad_sum_s[31:0];
    end
  end

endmodule

// File: rtl/hex_event_batcher.sv
// Packs single hex fragments into fixed-size single-material batches for the event writer.
// Define HEX_BATCH_STATS_EN to add the stat_batches / stat_pad_slots counters.
module hex_event_batcher
  import hex_raster_pkg::*;
#(
  parameter int         BATCH     = HEX_BATCH,
  parameter hex_depth_t PAD_DEPTH = HEX_PAD_DEPTH,
  parameter hex_coord_t PAD_COORD = HEX_PAD_COORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_q,
  input  logic signed [15:0] in_r,
  input  logic [7:0]         in_depth,
  input  logic [7:0]         in_material,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_q     [0:BATCH-1],
  output logic signed [15:0] out_r     [0:BATCH-1],
  output logic [7:0]         out_depth [0:BATCH-1],
  output logic [7:0]         out_material,
  output logic [3:0]         out_count
`ifdef HEX_BATCH_STATS_EN
  ,
  output logic [31:0]        stat_batches,
  output logic [31:0]        stat_pad_slots
`endif
);

  batch_state_e state_r, state_nxt_s;
  logic [3:0]   count_r, count_nxt_s, slot_s;
  hex_mat_t     cur_mat_r;
  hex_coord_t   fill_q_r     [BATCH];
  hex_coord_t   fill_r_r     [BATCH];
  hex_depth_t   fill_depth_r [BATCH];

  logic out_free_s, mismatch_s, accept_s, transfer_s, closes_s;

  // Handshake, transfer decision and slot addressing.
  always_comb begin
    out_free_s  = !out_valid || out_ready;
    mismatch_s  = in_valid && (state_r == ST_FILLING) && (in_material != cur_mat_r);
    in_ready    = ((state_r != ST_FLUSH) || out_free_s) && !mismatch_s && !frame_start;
    accept_s    = in_valid && in_ready;
    transfer_s  = (state_r == ST_FLUSH) && out_free_s && !frame_start;
    // A hex accepted while the batch moves out starts the next batch at slot 0.
    slot_s      = transfer_s ? 4'd0 : count_r;
    closes_s    = in_last || (slot_s == 4'(BATCH - 1));
    count_nxt_s = frame_start ? 4'd0 : (slot_s + {3'd0, accept_s});
  end

  // Next-state logic; frame_start overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (frame_start) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = closes_s ? ST_FLUSH : ST_FILLING;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FILLING: begin
          if ((accept_s && closes_s) || mismatch_s) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_FILLING;
          end
        end
        ST_FLUSH: begin
          if (!transfer_s) begin
            state_nxt_s = ST_FLUSH;
          end else if (accept_s) begin
            state_nxt_s = closes_s ? ST_FLUSH : ST_FILLING;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Fill buffer, slot counter, current material and state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      count_r   <= 4'd0;
      cur_mat_r <= 8'd0;
      for (int i = 0; i < BATCH; i++) begin
        fill_q_r[i]     <= 16'sd0;
        fill_r_r[i]     <= 16'sd0;
        fill_depth_r[i] <= 8'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (accept_s) begin
        fill_q_r[slot_s]     <= in_q;
        fill_r_r[slot_s]     <= in_r;
        fill_depth_r[slot_s] <= in_depth;
        if (slot_s == 4'd0) begin
          cur_mat_r <= in_material;
        end
      end
    end
  end

  // Output register: loaded on transfer, held under backpressure, dropped on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_count    <= 4'd0;
      out_material <= 8'd0;
      for (int i = 0; i < BATCH; i++) begin
        out_q[i]     <= 16'sd0;
        out_r[i]     <= 16'sd0;
        out_depth[i] <= 8'd0;
      end
    end else if (frame_start) begin
      out_valid <= 1'b0;
    end else if (transfer_s) begin
      for (int i = 0; i < BATCH; i++) begin
        out_q[i]     <= (4'(i) < count_r) ? fill_q_r[i]     : PAD_COORD;
        out_r[i]     <= (4'(i) < count_r) ? fill_r_r[i]     : PAD_COORD;
        out_depth[i] <= (4'(i) < count_r) ? fill_depth_r[i] : PAD_DEPTH;
      end
      out_count    <= count_r;
      out_material <= cur_mat_r;
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HEX_BATCH_STATS_EN
  hex_batch_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .clear          (frame_start),
    .transfer       (transfer_s),
    .pad_add        (4'(BATCH) - count_r),
    .stat_batches   (stat_batches),
    .stat_pad_slots (stat_pad_slots)
  );
`endif

endmodule

// File: tb/tb_hex_event_batcher.sv
// Self-checking bench for hex_event_batcher: directed vector table, corner sequences, random vs. queue model.
module tb_hex_event_batcher;
  import hex_raster_pkg::*;

  localparam int B = 10;

  logic clk = 1'b0;
  logic reset, frame_start, in_valid, in_ready, in_last, out_valid, out_ready;
  logic signed [15:0] in_q, in_r;
  logic [7:0] in_depth, in_material, out_material;
  logic [3:0] out_count;
  logic signed [15:0] out_q [0:B-1];
  logic signed [15:0] out_r [0:B-1];
  logic [7:0] out_depth [0:B-1];
`ifdef HEX_BATCH_STATS_EN
  logic [31:0] stat_batches, stat_pad_slots;
`endif

  always #5 clk = ~clk;

  hex_event_batcher dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_r(in_r),
    .in_depth(in_depth), .in_material(in_material), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_depth(out_depth), .out_material(out_material), .out_count(out_count)
`ifdef HEX_BATCH_STATS_EN
    , .stat_batches(stat_batches), .stat_pad_slots(stat_pad_slots)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pending hexes in a queue, one held output batch.
  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] r;
    logic [7:0]         d;
  } hex_t;

  hex_t       fill[$];
  hex_t       m_out[B];
  logic [7:0] m_mat, m_omat;
  int         m_ocnt;
  bit         m_flush, m_ov;
  longint     m_sb, m_sp;
  bit         pre_rdy, last_acc;

  task automatic model_reset();
    fill.delete();
    m_mat = 8'd0; m_omat = 8'd0; m_ocnt = 0;
    m_flush = 1'b0; m_ov = 1'b0; m_sb = 0; m_sp = 0;
    for (int i = 0; i < B; i++) m_out[i] = '0;
  endtask

  task automatic check_outputs(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < B; i++) begin
      if (out_q[i] !== m_out[i].q || out_r[i] !== m_out[i].r || out_depth[i] !== m_out[i].d) nbad++;
    end
    chk({tag, "_out_valid"}, out_valid, m_ov);
    chk({tag, "_out_count"}, out_count, m_ocnt);
    chk({tag, "_out_material"}, out_material, m_omat);
    chk({tag, "_bad_slots"}, nbad, 0);
`ifdef HEX_BATCH_STATS_EN
    chk({tag, "_stat_batches"}, stat_batches, m_sb);
    chk({tag, "_stat_pad_slots"}, stat_pad_slots, m_sp);
`endif
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    bit free, mism, rdy, acc, xfer, fs, lst, ordy;
    logic [7:0] mat;
    hex_t h, pad;
    pad = '{16'sh8000, 16'sh8000, 8'hFF};
    #1;
    free = !m_ov || out_ready;
    mism = in_valid && fill.size() > 0 && !m_flush && in_material != m_mat;
    rdy  = (!m_flush || free) && !mism && !frame_start;
    chk("in_ready", in_ready, rdy);
    pre_rdy = in_ready;
    acc  = in_valid && rdy;
    xfer = m_flush && free && !frame_start;
    fs = frame_start; lst = in_last; ordy = out_ready; mat = in_material;
    h = '{in_q, in_r, in_depth};
    last_acc = acc;
    @(posedge clk);
    if (fs) begin
      fill.delete(); m_flush = 1'b0; m_ov = 1'b0; m_sb = 0; m_sp = 0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < B; i++) m_out[i] = (i < fill.size()) ? fill[i] : pad;
        m_ocnt = fill.size();
        m_omat = m_mat;
        m_ov   = 1'b1;
        m_sb   = m_sb + 1;
        m_sp   = m_sp + (B - fill.size());
        fill.delete();
        m_flush = 1'b0;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        if (fill.size() == 0) m_mat = mat;
        fill.push_back(h);
        if (lst || fill.size() == B) m_flush = 1'b1;
      end
      if (mism) m_flush = 1'b1;
    end
    #1;
    check_outputs("step");
  endtask

  task automatic drive(input bit iv, input int q, input int mat, input bit last);
    in_valid = iv; in_q = 16'(q); in_r = 16'(-q); in_depth = 8'(q);
    in_material = 8'(mat); in_last = last;
  endtask

  typedef struct {
    bit iv; int q; int mat; bit last;
    bit rdy; bit ov; int cnt; int omat; int q0; int q9;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit iv, input int q, input int mat, input bit last, input bit rdy,
                     input bit ov, input int cnt, input int omat, input int q0, input int q9);
    vec_t v;
    v = '{iv, q, mat, last, rdy, ov, cnt, omat, q0, q9};
    vq.push_back(v);
  endtask

  initial begin
    int sent;
    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full batch, partial batch, material change.
    for (int i = 0; i < 10; i++) add(1, i, 3, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 10, 3, 0, 9);
    add(0, 0, 0, 0, 1, 0, 10, 3, 0, 9);
    add(1, 100, 5, 0, 1, 0, 10, 3, 0, 9);
    add(1, 101, 5, 0, 1, 0, 10, 3, 0, 9);
    add(1, 102, 5, 1, 1, 0, 10, 3, 0, 9);
    add(0, 0, 0, 0, 1, 1, 3, 5, 100, -32768);
    add(0, 0, 0, 0, 1, 0, 3, 5, 100, -32768);
    for (int k = 0; k < 4; k++) add(1, 200 + k, 1, 0, 1, 0, 3, 5, 100, -32768);
    add(1, 300, 2, 0, 0, 0, 3, 5, 100, -32768);
    add(1, 300, 2, 0, 1, 1, 4, 1, 200, -32768);
    add(1, 301, 2, 1, 1, 0, 4, 1, 200, -32768);
    add(0, 0, 0, 0, 1, 1, 2, 2, 300, -32768);
    add(0, 0, 0, 0, 1, 0, 2, 2, 300, -32768);
    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].q, vq[i].mat, vq[i].last);
      step();
      chk($sformatf("tbl%0d_in_ready", i), pre_rdy, vq[i].rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, vq[i].ov);
      chk($sformatf("tbl%0d_out_count", i), out_count, vq[i].cnt);
      chk($sformatf("tbl%0d_out_material", i), out_material, vq[i].omat);
      chk($sformatf("tbl%0d_out_q0", i), out_q[0], vq[i].q0);
      chk($sformatf("tbl%0d_out_q9", i), out_q[9], vq[i].q9);
    end

    // Backpressure: 20 hexes offered over 30 blocked cycles.
    out_ready = 1'b0; sent = 0;
    for (int c = 0; c < 30; c++) begin
      drive(sent < 20, 1000 + sent, 7, 1'b0);
      step();
      if (last_acc) sent++;
    end
    chk("bp_accepts", sent, 20);
    drive(1'b0, 0, 7, 1'b0);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_held_q0", out_q[0], 1000);
    out_ready = 1'b1;
    step();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_q0", out_q[0], 1010);
    step();
    chk("bp_drained", out_valid, 0);

    // frame_start at count 5 with a held batch.
    out_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 2000 + k, 4, 1'b0);
      step();
    end
    frame_start = 1'b1;
    drive(1'b1, 2100, 4, 1'b0);
    step();
    frame_start = 1'b0;
    chk("fs_out_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 2200, 6, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b0);
    step();
    chk("fs_new_valid", out_valid, 1);
    chk("fs_new_count", out_count, 1);
    chk("fs_new_q0", out_q[0], 2200);
    step();

    // Asynchronous reset with a held batch and a partial fill.
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive(1'b1, 3000 + k, 9, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    chk("async_reset_in_ready", in_ready, 1);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      frame_start = ($urandom_range(0, 99) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 2), $urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
